// File: rtl/rf_wb_arbiter.sv
// ============================================================================
// rf_wb_arbiter : round-robin write-back arbiter for the register-file port;
// define RF_WB_PERF_EN to add conflict_cnt.                      Rev 1.0
// ============================================================================
`default_nettype none

module rf_wb_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 32,
    parameter int AW   = 5
) (
    input  logic                 clk,
    input  logic                 reset_l,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_dest,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 rf_stall,
    output logic                 rf_we,
    output logic [AW-1:0]        rf_dest,
    output logic [DW-1:0]        rf_data,
`ifdef RF_WB_PERF_EN
    output logic [31:0]          conflict_cnt,
`endif
    output logic [31:0]          pend_mask
);

    localparam int            PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PW-1:0] LAST = PW'(NREQ - 1);

    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic            we_q, we_d;
    logic [AW-1:0]   dest_q, dest_d;
    logic [DW-1:0]   data_q, data_d;
    logic [NREQ-1:0] grant;
    logic [PW-1:0]   gidx;
    logic            xfer;

    // First valid requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        int   idx;
        logic found;
        found = 1'b0;
        gidx  = '0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                gidx  = PW'(idx);
            end
        end
        xfer  = found && !rf_stall;
        grant = xfer ? (NREQ'(1) << gidx) : '0;
    end

    assign req_ready = reset_l ? grant : '0;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        we_d     = 1'b0;
        dest_d   = dest_q;
        data_d   = data_q;
        if (xfer) begin
            rr_ptr_d = (gidx == LAST) ? '0 : gidx + PW'(1);
            dest_d   = req_dest[gidx*AW +: AW];
            data_d   = req_data[gidx*DW +: DW];
            we_d     = (req_dest[gidx*AW +: AW] != '0);
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            rr_ptr_q <= '0;
            we_q     <= 1'b0;
            dest_q   <= '0;
            data_q   <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            we_q     <= we_d;
            dest_q   <= dest_d;
            data_q   <= data_d;
        end
    end

    assign rf_we   = we_q;
    assign rf_dest = dest_q;
    assign rf_data = data_q;

    // Register 0 is hardwired, so it never counts as a pending hazard.
    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i]) pend_mask[req_dest[i*AW +: AW]] = 1'b1;
        end
        if (we_q) pend_mask[dest_q] = 1'b1;
        pend_mask[0] = 1'b0;
    end

`ifdef RF_WB_PERF_EN
    logic [31:0] cc_q;
    logic        multi;

    assign multi = ((req_valid & (req_valid - NREQ'(1))) != '0);

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            cc_q <= '0;
        end else if (!rf_stall && multi && (cc_q != 32'hFFFF_FFFF)) begin
            cc_q <= cc_q + 32'd1;
        end
    end

    assign conflict_cnt = cc_q;
`endif

    generate
        for (genvar i = 0; i < NREQ; i++) begin : g_hold_chk
            a_valid_held : assert property (@(posedge clk) disable iff (!reset_l)
                (req_valid[i] && !req_ready[i]) |=> req_valid[i]);
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
// ============================================================================
// tb_rf_wb_arbiter : vector table, random stimulus against a reference model,
// and reset corner cases for rf_wb_arbiter.                       Rev 1.0
// ============================================================================
`default_nettype none

module tb_rf_wb_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 32;
    localparam int AW   = 5;

    logic                clk = 1'b0;
    logic                reset_l;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*AW-1:0]  req_dest;
    logic [NREQ*DW-1:0]  req_data;
    logic [NREQ-1:0]     req_ready;
    logic                rf_stall;
    logic                rf_we;
    logic [AW-1:0]       rf_dest;
    logic [DW-1:0]       rf_data;
    logic [31:0]         pend_mask;
`ifdef RF_WB_PERF_EN
    logic [31:0]         conflict_cnt;
`endif

    rf_wb_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .reset_l   (reset_l),
        .req_valid (req_valid),
        .req_dest  (req_dest),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rf_stall  (rf_stall),
        .rf_we     (rf_we),
        .rf_dest   (rf_dest),
        .rf_data   (rf_data),
`ifdef RF_WB_PERF_EN
        .conflict_cnt (conflict_cnt),
`endif
        .pend_mask (pend_mask)
    );

    always #5 clk = ~clk;

    int ncmp = 0;
    int nerr = 0;

    // Reference model state
    int          m_ptr;
    logic        m_we;
    logic [4:0]  m_dest;
    logic [31:0] m_data;
    logic [31:0] m_cc;
    logic [3:0]  s_ready;
    int          wait_cnt [NREQ];

    typedef struct {
        logic [3:0]   v;
        logic         st;
        logic [19:0]  d;
        logic [127:0] dat;
        logic [3:0]   rdy;
        logic         we;
        logic [4:0]   rd;
        logic [31:0]  rdat;
    } vec_t;

    localparam logic [19:0]  DA = {5'd4, 5'd3, 5'd2, 5'd1};
    localparam logic [127:0] TA = {32'h44, 32'h33, 32'h22, 32'h11};
    vec_t tbl [17];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_we   = 1'b0;
        m_dest = '0;
        m_data = '0;
        m_cc   = '0;
        for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
    endtask

    // Called just after a rising edge with inputs already driven.
    task automatic run_cycle();
        int          g;
        logic [31:0] pend;
        logic [4:0]  gd;
        logic [31:0] gdat;
        int          nv;
        #4;
        g = -1;
        if (!rf_stall) begin
            for (int k = 0; k < NREQ; k++) begin
                int idx = (m_ptr + k) % NREQ;
                if (g < 0 && req_valid[idx]) g = idx;
            end
        end
        pend = '0;
        for (int i = 0; i < NREQ; i++)
            if (req_valid[i]) pend[req_dest[i*AW +: AW]] = 1'b1;
        if (m_we) pend[m_dest] = 1'b1;
        pend[0] = 1'b0;
        s_ready = req_ready;
        chk("ready", {60'd0, req_ready}, (g < 0) ? 64'd0 : (64'd1 << g));
        chk("pend_mask", {32'd0, pend_mask}, {32'd0, pend});
        nv   = $countones(req_valid);
        gd   = (g < 0) ? 5'd0 : req_dest[g*AW +: AW];
        gdat = (g < 0) ? 32'd0 : req_data[g*DW +: DW];
        @(posedge clk);
        #1;
        if (!rf_stall && nv >= 2 && m_cc != 32'hFFFF_FFFF) m_cc = m_cc + 1;
        if (g >= 0) begin
            m_we   = (gd != 5'd0);
            m_dest = gd;
            m_data = gdat;
            m_ptr  = (g + 1) % NREQ;
        end else begin
            m_we = 1'b0;
        end
        chk("rf_we", {63'd0, rf_we}, {63'd0, m_we});
        chk("rf_dest", {59'd0, rf_dest}, {59'd0, m_dest});
        chk("rf_data", {32'd0, rf_data}, {32'd0, m_data});
`ifdef RF_WB_PERF_EN
        chk("conflict_cnt", {32'd0, conflict_cnt}, {32'd0, m_cc});
`endif
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{4'b0000, 1'b0, DA, TA, 4'b0000, 1'b0, 5'd0, 32'h0};
        tbl[1]  = '{4'b0010, 1'b0, {5'd4,5'd3,5'd7,5'd1}, {32'h44,32'h33,32'hDEADBEEF,32'h11},
                    4'b0010, 1'b1, 5'd7, 32'hDEADBEEF};
        tbl[2]  = '{4'b1111, 1'b0, DA, TA, 4'b0100, 1'b1, 5'd3, 32'h33};
        tbl[3]  = '{4'b1011, 1'b0, DA, TA, 4'b1000, 1'b1, 5'd4, 32'h44};
        tbl[4]  = '{4'b0011, 1'b0, DA, TA, 4'b0001, 1'b1, 5'd1, 32'h11};
        tbl[5]  = '{4'b0010, 1'b0, DA, TA, 4'b0010, 1'b1, 5'd2, 32'h22};
        tbl[6]  = '{4'b0100, 1'b0, {5'd4,5'd0,5'd2,5'd1}, {32'h44,32'h55,32'h22,32'h11},
                    4'b0100, 1'b0, 5'd0, 32'h55};
        tbl[7]  = '{4'b0000, 1'b0, DA, TA, 4'b0000, 1'b0, 5'd0, 32'h55};
        tbl[8]  = '{4'b1000, 1'b0, DA, TA, 4'b1000, 1'b1, 5'd4, 32'h44};
        tbl[9]  = '{4'b1111, 1'b0, DA, TA, 4'b0001, 1'b1, 5'd1, 32'h11};
        tbl[10] = '{4'b1110, 1'b0, DA, TA, 4'b0010, 1'b1, 5'd2, 32'h22};
        tbl[11] = '{4'b1100, 1'b0, DA, TA, 4'b0100, 1'b1, 5'd3, 32'h33};
        tbl[12] = '{4'b1000, 1'b0, DA, TA, 4'b1000, 1'b1, 5'd4, 32'h44};
        for (int j = 13; j < 16; j++)
            tbl[j] = '{4'b0001, 1'b1, {5'd4,5'd3,5'd2,5'd9}, {32'h44,32'h33,32'h22,32'h99},
                       4'b0000, 1'b0, 5'd4, 32'h44};
        tbl[16] = '{4'b0001, 1'b0, {5'd4,5'd3,5'd2,5'd9}, {32'h44,32'h33,32'h22,32'h99},
                    4'b0001, 1'b1, 5'd9, 32'h99};

        // Reset: ready must stay low even with requests present.
        reset_l   = 1'b0;
        rf_stall  = 1'b0;
        req_valid = '1;
        req_dest  = DA;
        req_data  = TA;
        model_reset();
        #3;
        chk("reset_ready", {60'd0, req_ready}, 64'd0);
        chk("reset_we", {63'd0, rf_we}, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        req_valid = '0;
        reset_l   = 1'b1;

        for (int c = 0; c < 5; c++) run_cycle();

        for (int j = 0; j < 17; j++) begin
            req_valid = tbl[j].v;
            rf_stall  = tbl[j].st;
            req_dest  = tbl[j].d;
            req_data  = tbl[j].dat;
            run_cycle();
            chk($sformatf("tbl%0d_ready", j), {60'd0, s_ready}, {60'd0, tbl[j].rdy});
            chk($sformatf("tbl%0d_we", j), {63'd0, rf_we}, {63'd0, tbl[j].we});
            chk($sformatf("tbl%0d_dest", j), {59'd0, rf_dest}, {59'd0, tbl[j].rd});
            chk($sformatf("tbl%0d_data", j), {32'd0, rf_data}, {32'd0, tbl[j].rdat});
        end

        // Random traffic; a requester only changes its request once accepted.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] || s_ready[i]) begin
                    req_valid[i]         = ($urandom_range(0, 2) != 0);
                    req_dest[i*AW +: AW] = 5'($urandom_range(0, 7));
                    req_data[i*DW +: DW] = $urandom;
                end
            end
            rf_stall = ($urandom_range(0, 3) == 0);
            run_cycle();
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && !rf_stall) wait_cnt[i]++;
                if (s_ready[i]) begin
                    chk($sformatf("fair_wait%0d", i), {63'd0, (wait_cnt[i] <= NREQ)}, 64'd1);
                    wait_cnt[i] = 0;
                end
            end
        end

        // Drain outstanding requests before the reset sequence.
        rf_stall = 1'b0;
        for (int c = 0; c < 20; c++) begin
            req_valid = req_valid & ~s_ready;
            if (req_valid == '0) break;
            run_cycle();
        end
        req_valid = req_valid & ~s_ready;

        // Asynchronous reset while a write is on the output.
        req_valid = 4'b0001;
        req_dest  = {5'd4, 5'd3, 5'd2, 5'd5};
        req_data  = {32'h44, 32'h33, 32'h22, 32'hA5A5A5A5};
        run_cycle();
        chk("pre_reset_we", {63'd0, rf_we}, 64'd1);
        req_valid = 4'b1111;
        req_dest  = DA;
        req_data  = TA;
        #1;
        reset_l = 1'b0;
        #1;
        chk("async_we", {63'd0, rf_we}, 64'd0);
        chk("async_dest", {59'd0, rf_dest}, 64'd0);
        chk("async_data", {32'd0, rf_data}, 64'd0);
        chk("async_ready", {60'd0, req_ready}, 64'd0);
`ifdef RF_WB_PERF_EN
        chk("async_cc", {32'd0, conflict_cnt}, 64'd0);
`endif
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_l = 1'b1;
        run_cycle();
        chk("ptr_after_reset", {60'd0, s_ready}, 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port among NREQ write-back requesters (ALU, load unit, multiplier/divider, CP0 move).
- Round-robin grant over a valid/ready handshake. The winner's write is registered and presented to the register file one cycle later.
- Drops writes to register 0, and exports a pending-destination mask for the hazard/stall logic.

Parameters:
- NREQ, 4, number of write-back requesters (2..8)
- DW, 32, register data width
- AW, 5, register index width (32 registers)

Ports:
- clk  in  1  rising-edge clock
- reset_l  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  requester i has a write pending
- req_dest  in  NREQ*AW  destination index; slice i = bits [i*AW +: AW]
- req_data  in  NREQ*DW  write data; slice i = bits [i*DW +: DW]
- req_ready  out  NREQ  one-hot grant; transfer when req_valid[i] & req_ready[i]
- rf_stall  in  1  register file unavailable; blocks all grants
- rf_we  out  1  registered write enable to register file
- rf_dest  out  AW  registered write index
- rf_data  out  DW  registered write data
- pend_mask  out  32  bit d set if register d has an outstanding write

Behaviour:
- Reset (async, reset_l=0):
  - rf_we=0, rf_dest=0, rf_data=0.
  - Round-robin pointer rr_ptr=0.
  - req_ready=0 while reset_l=0.
  - In-flight output write is discarded. Requesters are reset by the same signal.
- Grant (combinational, same cycle):
  - If rf_stall=0 and any req_valid is set, grant the first valid requester searching from rr_ptr upward, modulo NREQ.
  - req_ready is one-hot or zero. No grant when rf_stall=1.
  - req_ready never depends on itself. req_valid must not depend on req_ready.
- Handshake:
  - A requester holds valid/dest/data stable until accepted.
  - Deasserting valid without acceptance is illegal and flagged by a simulation assertion.
- Pointer update:
  - On a transfer from requester g, rr_ptr <= (g+1) mod NREQ.
  - No transfer: rr_ptr holds.
- Output stage (latency exactly 1 cycle):
  - Cycle after a transfer: rf_dest/rf_data = granted dest/data.
  - rf_we=1 only if that dest != 0.
  - Dest=0 transfers are consumed (ready asserted) but produce rf_we=0. rf_dest/rf_data still update.
- No transfer in a cycle: rf_we<=0 next cycle; rf_dest/rf_data hold their previous values.
- rf_stall=1: no grants, so rf_we=0 on the following cycle. A write already registered still completes this cycle.
- pend_mask (combinational):
  - OR over i of (req_valid[i] ? onehot(req_dest[i]) : 0), OR onehot(rf_dest) when rf_we=1.
  - Bit 0 is always 0.
- Same destination from multiple requesters: serialized in grant order. The register file ends with the last-granted data.
- Fairness: any requester holding valid is granted within NREQ non-stalled cycles.
- Throughput: one write per non-stalled cycle, sustained.

Optional Feature:
- Macro RF_WB_PERF_EN.
- Defined: adds output conflict_cnt (32 bits, reset 0).
  - Increments by 1 each cycle with rf_stall=0 and two or more req_valid set.
  - Saturates at 0xFFFFFFFF.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset release, all req_valid=0 for 5 cycles -> rf_we=0, rf_dest=0, rf_data=0, req_ready=0, pend_mask=0 throughout.
- req_valid=4'b0010, dest1=7, data1=0xDEADBEEF -> req_ready=4'b0010 same cycle; next cycle rf_we=1, rf_dest=7, rf_data=0xDEADBEEF; rr_ptr=2.
- req_valid=4'b1111 held 4 cycles from rr_ptr=0, dests 1..4 -> grants 0,1,2,3 in order; rf_dest sequence 1,2,3,4 one cycle later; rf_we=1 each cycle.
- Requester 2 dest=0, data=0x55 -> req_ready[2]=1; next cycle rf_we=0, rf_dest=0; pend_mask bit0 stays 0.
- req_valid=4'b0001, dest=9, rf_stall=1 for 3 cycles -> req_ready=0, pend_mask[9]=1, rf_we=0; stall drops -> grant, rf_we=1, rf_dest=9 next cycle.
- Assert reset_l=0 mid-stream with rf_we=1 -> rf_we=0 immediately (async); rr_ptr=0 after release; with RF_WB_PERF_EN, conflict_cnt=0.
